// File: rtl/rhd_spi_master.sv
// rhd_spi_master: SPI master for RHD-style front ends, 16-bit commands out, MISO words captured.
// Define RHD_SPI_MISO_DDR_EN to capture word B (ch 32-63) as well as word A (ch 0-31).
module rhd_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DLY = 2,
    parameter int CS_SETUP   = 2,
    parameter int CS_GAP     = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_a,
    output logic [15:0] rsp_b,
    output logic        busy,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    // Sample points are located by SCLK half-period index plus a clk offset inside that half;
    // a delay of a full half or more pushes every sample one half later.
    localparam int LATE = (SAMPLE_DLY >= CLK_DIV) ? 1 : 0;
    localparam logic [15:0] SMP_OFS   = 16'(SAMPLE_DLY - LATE * CLK_DIV);
    localparam logic [15:0] HALF_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);
    localparam logic [5:0]  A_FIRST   = 6'(1 + LATE);
    localparam logic [5:0]  A_LAST    = 6'(31 + LATE);
`ifdef RHD_SPI_MISO_DDR_EN
    localparam logic [5:0]  FINAL_HN  = 6'(32 + LATE);
`else
    localparam logic [5:0]  FINAL_HN  = A_LAST;
`endif

    state_t      state;
    logic [15:0] cnt;
    logic [5:0]  hn;
    logic [15:0] sr;
    logic [15:0] cap_a;
    logic        done;
    logic        tick;
    logic        slot;
    logic        samp_a;
    logic        last_samp;
`ifdef RHD_SPI_MISO_DDR_EN
    logic [15:0] cap_b;
    logic        samp_b;
`else
    assign rsp_b = 16'h0000;
`endif

    // Half-period boundary and MISO sample strobes derived from the running frame phase
    always_comb begin
        tick      = cnt == HALF_END;
        slot      = (state == SHIFT || state == HOLD) && cnt == SMP_OFS;
        samp_a    = slot && hn >= A_FIRST && hn <= A_LAST && hn[0] == A_FIRST[0];
        last_samp = slot && hn == FINAL_HN;
`ifdef RHD_SPI_MISO_DDR_EN
        samp_b    = slot && hn > A_FIRST && hn <= A_LAST + 6'd1 && hn[0] != A_FIRST[0];
`endif
    end

    // Frame sequencer: command handshake, CS/SCLK/MOSI generation, capture and response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            hn        <= '0;
            sr        <= '0;
            cap_a     <= '0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            busy      <= 1'b0;
            CS        <= 1'b1;
            SCLK      <= 1'b0;
            MOSI      <= 1'b0;
`ifdef RHD_SPI_MISO_DDR_EN
            cap_b     <= '0;
            rsp_b     <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        CS        <= 1'b0;
                        MOSI      <= cmd_data[15];
                        sr        <= {cmd_data[14:0], 1'b0};
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == SETUP_END) begin
                        SCLK  <= 1'b1;
                        cnt   <= '0;
                        hn    <= '0;
                        done  <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT, HOLD: begin
                    cnt <= tick ? '0 : cnt + 16'd1;
                    if (tick)
                        hn <= hn + 6'd1;
                    if (tick && state == SHIFT) begin
                        SCLK <= hn[0] && hn != 6'd31;
                        if (!hn[0]) begin
                            MOSI <= sr[15];
                            sr   <= {sr[14:0], 1'b0};
                        end
                        if (hn == 6'd31)
                            state <= HOLD;
                    end
                    if (samp_a)
                        cap_a <= {cap_a[14:0], MISO};
`ifdef RHD_SPI_MISO_DDR_EN
                    if (samp_b)
                        cap_b <= {cap_b[14:0], MISO};
`endif
                    if (last_samp)
                        done <= 1'b1;
                    if (state == HOLD && done) begin
                        CS        <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_a     <= cap_a;
`ifdef RHD_SPI_MISO_DDR_EN
                        rsp_b     <= cap_b;
`endif
                        cnt       <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == GAP_END) begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
